// File: rtl/simon_encrypt_sequencer.sv
// Iterative Simon32/64 encryptor: one round per clock with an on-the-fly key schedule
// held in a 4-word sliding window, and valid/ready handshakes on the input and output sides.
module simon_encrypt_sequencer #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_plntxt_i,
  input  logic [63:0] in_key_i,
  input  logic        abort_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_cphrtxt_o,
  output logic        busy_o,
  output logic [4:0]  round_idx_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Bit j of the z0 sequence is Z0[61-j]; the leftmost literal digit is j=0.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [5:0]  j_q, j_d;

  logic [15:0] f_x, t_k, knew;

  assign f_x  = ({x_q[14:0], x_q[15]} & {x_q[7:0], x_q[15:8]}) ^ {x_q[13:0], x_q[15:14]};
  assign t_k  = {w3_q[2:0], w3_q[15:3]} ^ w1_q;
  assign knew = ~w0_q ^ t_k ^ {t_k[0], t_k[15:1]} ^ 16'h0003 ^ {15'd0, Z0[6'd61 - j_q]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      rnd_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      rnd_q   <= rnd_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    rnd_d   = rnd_q;
    j_d     = j_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          x_d     = in_plntxt_i[31:16];
          y_d     = in_plntxt_i[15:0];
          w0_d    = in_key_i[15:0];
          w1_d    = in_key_i[31:16];
          w2_d    = in_key_i[47:32];
          w3_d    = in_key_i[63:48];
          rnd_d   = '0;
          j_d     = '0;
          state_d = StRun;
        end
      end
      StRun, StDone: begin
        if (abort_i) begin
          // Abort wipes the datapath so no partial state survives into the next job.
          x_d     = '0;
          y_d     = '0;
          w0_d    = '0;
          w1_d    = '0;
          w2_d    = '0;
          w3_d    = '0;
          rnd_d   = '0;
          j_d     = '0;
          state_d = StIdle;
        end else if (state_q == StRun) begin
          x_d   = y_q ^ f_x ^ w0_q;
          y_d   = x_q;
          w0_d  = w1_q;
          w1_d  = w2_q;
          w2_d  = w3_q;
          w3_d  = knew;
          j_d   = (j_q == 6'd61) ? 6'd0 : j_q + 6'd1;
          rnd_d = rnd_q + 5'd1;
          if (rnd_q == LastRound) begin
            rnd_d   = '0;
            state_d = StDone;
          end
        end else if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign out_cphrtxt_o = (state_q == StDone) ? {x_q, y_q} : 32'd0;
  assign busy_o        = (state_q != StIdle);
  assign round_idx_o   = (state_q == StRun) ? rnd_q : 5'd0;

endmodule

// File: tb/tb_simon_encrypt_sequencer.sv
// Directed bench for simon_encrypt_sequencer using the published Simon32/64 test vector.
module tb_simon_encrypt_sequencer;

  localparam logic [63:0] Key = 64'h1918111009080100;
  localparam logic [31:0] Pt  = 32'h65656877;
  localparam logic [31:0] Ct  = 32'hc69be9bb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_plntxt = '0;
  logic [63:0] in_key = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_cphrtxt;
  logic        busy;
  logic [4:0]  round_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simon_encrypt_sequencer #(.ROUNDS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_plntxt_i  (in_plntxt),
    .in_key_i     (in_key),
    .abort_i      (abort),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_cphrtxt_o(out_cphrtxt),
    .busy_o       (busy),
    .round_idx_o  (round_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_cphrtxt"}, 64'(out_cphrtxt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_round_idx"}, 64'(round_idx), 64'd0);
  endtask

  // Single-cycle offer of the standard vector; returns in cycle 1 of the run.
  task automatic accept_std();
    in_plntxt = Pt;
    in_key    = Key;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] first_ct;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Standard vector, out_ready held high
    out_ready = 1'b1;
    accept_std();
    chk("std_busy_c1", 64'(busy), 64'd1);
    chk("std_in_ready_c1", 64'(in_ready), 64'd0);
    chk("std_round_c1", 64'(round_idx), 64'd0);
    for (int i = 0; i < 5; i++) step();
    chk("std_round_c6", 64'(round_idx), 64'd5);
    wait_valid("std", n);
    chk("std_latency", 64'(n + 5), 64'd32);
    chk("std_ct", 64'(out_cphrtxt), 64'(Ct));
    step();
    chk("std_valid_one_cycle", 64'(out_valid), 64'd0);
    chk("std_ct_zero_after", 64'(out_cphrtxt), 64'd0);
    chk("std_in_ready_after", 64'(in_ready), 64'd1);

    // Backpressure: hold the result for 10 cycles
    out_ready = 1'b0;
    accept_std();
    wait_valid("bp", n);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_ct_held", 64'(out_cphrtxt), 64'(Ct));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_valid_dropped", 64'(out_valid), 64'd0);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);

    // Back-to-back with in_valid held high
    in_plntxt = Pt;
    in_key    = Key;
    in_valid  = 1'b1;
    step();
    n = 0;
    first_ct = '0;
    while (!in_ready && n < 60) begin
      step();
      n++;
      if (out_valid) first_ct = out_cphrtxt;
    end
    chk("b2b_spacing", 64'(n + 1), 64'd34);
    chk("b2b_ct1", 64'(first_ct), 64'(Ct));
    step();
    in_valid = 1'b0;
    chk("b2b_second_accepted", 64'(busy), 64'd1);
    wait_valid("b2b2", n);
    chk("b2b_ct2", 64'(out_cphrtxt), 64'(Ct));
    step();

    // Inputs change mid-run are ignored
    accept_std();
    for (int i = 0; i < 10; i++) step();
    chk("chg_round10", 64'(round_idx), 64'd10);
    in_plntxt = 32'h0;
    in_key    = 64'h0;
    wait_valid("chg", n);
    chk("chg_ct", 64'(out_cphrtxt), 64'(Ct));
    step();

    // Abort in round 15
    accept_std();
    for (int i = 0; i < 15; i++) step();
    chk("abort_round15", 64'(round_idx), 64'd15);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_reset_outputs("abort");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);

    // Abort in IDLE is ignored and the offered pair is still accepted
    in_plntxt = Pt;
    in_key    = Key;
    in_valid  = 1'b1;
    abort     = 1'b1;
    step();
    in_valid  = 1'b0;
    abort     = 1'b0;
    chk("abort_idle_accept", 64'(busy), 64'd1);
    wait_valid("post_abort", n);
    chk("post_abort_ct", 64'(out_cphrtxt), 64'(Ct));

    // Abort in DONE beats out_ready
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done_valid", 64'(out_valid), 64'd0);
    chk("abort_done_busy", 64'(busy), 64'd0);

    // Reset in round 20
    accept_std();
    for (int i = 0; i < 20; i++) step();
    chk("rst_round20", 64'(round_idx), 64'd20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_run");

    // Reset while result is held in DONE
    out_ready = 1'b0;
    accept_std();
    wait_valid("rst_done", n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_done");
    out_ready = 1'b1;

    // Reset coincident with in_valid: pair must not be accepted
    in_plntxt = Pt;
    in_key    = Key;
    in_valid  = 1'b1;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    chk("rst_vs_valid_busy", 64'(busy), 64'd0);
    chk("rst_vs_valid_ready", 64'(in_ready), 64'd1);
    step();
    chk("rst_vs_valid_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
